// File: rtl/mac_tri_sequencer.sv
// Sequences one polynomial job, (a*x+b)*x+c or a*x+b, through an external MAC unit
// and returns the MAC result over a valid/ready handshake.
module mac_tri_sequencer #(
  parameter int RESULT_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [7:0]  job_a,
  input  logic [7:0]  job_x,
  input  logic [7:0]  job_b,
  input  logic [7:0]  job_c,
  input  logic        job_mode,
  output logic [7:0]  in_1,
  output logic [7:0]  in_2,
  output logic [7:0]  in_add,
  output logic        mode,
  output logic        mul_input_mux,
  output logic        adder_input_mux,
  input  logic [15:0] mac_output,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [7:0]  jobs_done
);

  localparam logic [3:0] LAT_INIT = 4'(RESULT_LAT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, DONE} state_t;

  state_t     state;
  logic [7:0] a_q;
  logic [7:0] x_q;
  logic [7:0] b_q;
  logic [7:0] c_q;
  logic       mode_q;
  logic [3:0] cnt;

  assign job_ready = (state == IDLE);

  // MAC drives are registered one state ahead so they are valid throughout LOAD/FEED
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      a_q             <= '0;
      x_q             <= '0;
      b_q             <= '0;
      c_q             <= '0;
      mode_q          <= 1'b0;
      cnt             <= '0;
      in_1            <= '0;
      in_2            <= '0;
      in_add          <= '0;
      mode            <= 1'b0;
      mul_input_mux   <= 1'b0;
      adder_input_mux <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      jobs_done       <= '0;
    end else begin
      in_1            <= '0;
      in_2            <= '0;
      in_add          <= '0;
      mode            <= 1'b0;
      mul_input_mux   <= 1'b0;
      adder_input_mux <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            a_q    <= job_a;
            x_q    <= job_x;
            b_q    <= job_b;
            c_q    <= job_c;
            mode_q <= job_mode;
            in_1   <= job_a;
            in_2   <= job_x;
            in_add <= job_b;
            mode   <= job_mode;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (mode_q) begin
            // second pass multiplies the accumulated a*x+b by x again and adds c
            in_1          <= a_q;
            in_2          <= x_q;
            in_add        <= c_q;
            mul_input_mux <= 1'b1;
            mode          <= 1'b1;
            state         <= FEED;
          end else begin
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        FEED: begin
          cnt   <= LAT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            res_data  <= mac_output;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
